// File: rtl/qspi_line_fetch.sv
// Quad Output Fast Read (6Bh) line prefetcher feeding a ping-pong nibble buffer.
// Optional feature macro: QSPI_FETCH_CHECKSUM_EN adds csum[7:0] (wrapping sum of the last fetch).
module qspi_line_fetch #(
    parameter int         NIBBLES    = 136,
    parameter int         DUMMY_CLKS = 8,
    parameter logic [7:0] CMD        = 8'h6B,
    parameter int         IDX_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       rd_data,
    output logic             busy,
    output logic             done,
    output logic             late,
    output logic             spi_cs,
    output logic             spi_sclk,
    input  logic [3:0]       spi_in,
    output logic             spi_out0,
    output logic             spi_dir0
`ifdef QSPI_FETCH_CHECKSUM_EN
    ,
    output logic [7:0]       csum
`endif
);

    localparam int DATA_START = 32 + DUMMY_CLKS;
    localparam int LAST_K     = DATA_START + NIBBLES - 1;
    localparam int CNT_W      = $clog2(LAST_K + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        shift_reg, shift_next;
    logic               cs_next, out0_next, dir0_next, busy_next, done_next;
    logic               cs_reg, out0_reg, dir0_reg, busy_reg, done_reg, late_reg;
    logic               rd_bank_reg, wr_bank_reg;
    logic               accept, write_en;
    logic [3:0]         cap_reg;
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         bank_rd [2];

    assign spi_sclk = ~clk;
    assign spi_cs   = cs_reg;
    assign spi_out0 = out0_reg;
    assign spi_dir0 = dir0_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign late     = late_reg;

    // Control outputs are computed for the cycle being entered, then registered.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        shift_next = shift_reg;
        cs_next    = 1'b0;
        out0_next  = 1'b0;
        dir0_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        accept     = 1'b0;
        write_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_CMD;
                    cs_next    = 1'b1;
                    busy_next  = 1'b1;
                    out0_next  = CMD[7];
                    shift_next = {CMD[6:0], addr, 1'b0};
                end
            end
            ST_CMD, ST_ADDR: begin
                cs_next    = 1'b1;
                busy_next  = 1'b1;
                out0_next  = shift_reg[31];
                shift_next = {shift_reg[30:0], 1'b0};
                if (state_reg == ST_CMD && cnt_reg == CNT_W'(7))
                    state_next = ST_ADDR;
                if (cnt_reg == CNT_W'(31)) begin
                    state_next = (DUMMY_CLKS == 0) ? ST_DATA : ST_DUMMY;
                    out0_next  = 1'b0;
                    dir0_next  = 1'b1;
                end
            end
            ST_DUMMY: begin
                cs_next   = 1'b1;
                busy_next = 1'b1;
                dir0_next = 1'b1;
                if (cnt_reg == CNT_W'(DATA_START - 1))
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                write_en = 1'b1;
                if (cnt_reg == CNT_W'(LAST_K)) begin
                    state_next = ST_END;
                    done_next  = 1'b1;
                end else begin
                    cs_next   = 1'b1;
                    busy_next = 1'b1;
                    dir0_next = 1'b1;
                end
            end
            ST_END: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            cs_reg      <= 1'b0;
            out0_reg    <= 1'b0;
            dir0_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            late_reg    <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            cs_reg      <= cs_next;
            out0_reg    <= out0_next;
            dir0_reg    <= dir0_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            late_reg    <= swap & busy_reg;
            rd_bank_reg <= rd_bank_reg ^ swap;
            // A same-cycle swap is applied before choosing the write bank.
            if (accept)
                wr_bank_reg <= ~(rd_bank_reg ^ swap);
        end
    end

    // The flash drives after the falling SCLK edge, so sample mid-cycle on negedge clk.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n)
            cap_reg <= '0;
        else if (state_reg == ST_DATA)
            cap_reg <= spi_in;
    end

    assign wr_idx = IDX_W'(cnt_reg - CNT_W'(DATA_START));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [3:0] mem [NIBBLES];
            always_ff @(posedge clk) begin
                if (write_en && wr_bank_reg == 1'(gi))
                    mem[wr_idx] <= cap_reg;
            end
            assign bank_rd[gi] = mem[rd_idx];
        end
    endgenerate

    assign rd_data = (int'(rd_idx) < NIBBLES) ? bank_rd[rd_bank_reg] : 4'h0;

`ifdef QSPI_FETCH_CHECKSUM_EN
    logic [7:0] acc_reg, csum_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg  <= '0;
            csum_reg <= '0;
        end else begin
            if (accept)
                acc_reg <= '0;
            else if (write_en)
                acc_reg <= acc_reg + {4'h0, cap_reg};
            if (write_en && done_next)
                csum_reg <= acc_reg + {4'h0, cap_reg};
        end
    end

    assign csum = csum_reg;
`endif

endmodule

// File: tb/tb_qspi_line_fetch.sv
// Directed bench for qspi_line_fetch: flash model on the QSPI pins plus bus/buffer checks.
module tb_qspi_line_fetch;

    localparam int NIBBLES = 136;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = '0;
    logic        swap = 1'b0;
    logic [7:0]  rd_idx = '0;
    logic [3:0]  spi_in = '0;
    logic [3:0]  rd_data;
    logic        busy, done, late, spi_cs, spi_sclk, spi_out0, spi_dir0;
`ifdef QSPI_FETCH_CHECKSUM_EN
    logic [7:0]  csum;
    logic [7:0]  csum_seen = '0;
`endif

    qspi_line_fetch dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .addr     (addr),
        .swap     (swap),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .late     (late),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_in   (spi_in),
        .spi_out0 (spi_out0),
        .spi_dir0 (spi_dir0)
`ifdef QSPI_FETCH_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Nibble j returned by the flash model in each pattern mode.
    function automatic logic [3:0] pat(input int mode, input int j);
        case (mode)
            0:       return 4'(j);
            1:       return 4'hF;
            2:       return 4'(j + 5);
            default: return 4'(j * 3);
        endcase
    endfunction

    // Flash model and bus monitor; k is the cs-high cycle index.
    int          k = -1;
    int          pat_mode = 0;
    int          cs_len = 0, done_cnt = 0, late_cnt = 0, dir_err = 0;
    logic [31:0] mosi_word = '0;

    always @(posedge clk) begin
        #1;
        if (spi_cs) k = k + 1;
        else        k = -1;
        spi_in = (k >= 40) ? pat(pat_mode, k - 40) : 4'h0;
    end

    always @(negedge clk) begin
        if (spi_cs) begin
            cs_len++;
            if (k >= 0 && k < 32) mosi_word[31-k] = spi_out0;
            if (spi_dir0 !== (k >= 32)) dir_err++;
        end
        if (done) begin
            done_cnt++;
`ifdef QSPI_FETCH_CHECKSUM_EN
            csum_seen = csum;
`endif
        end
        if (late) late_cnt++;
    end

    task automatic clear_mon();
        cs_len = 0; done_cnt = 0; late_cnt = 0; dir_err = 0; mosi_word = '0;
    endtask

    task automatic pulse_start(input logic [23:0] a);
        @(posedge clk); #2;
        addr = a; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic do_swap();
        @(posedge clk); #2;
        swap = 1'b1;
        @(posedge clk); #2;
        swap = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_k(input int target, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk); #2;
            if (k == target) hit = 1'b1;
        end
        check({tag, " reach_k"}, 32'(hit), 32'd1);
    endtask

    task automatic check_fetch(input string tag, input logic [23:0] a);
        check({tag, " mosi"}, mosi_word, {8'h6B, a});
        check({tag, " cs_len"}, 32'(cs_len), 32'd176);
        check({tag, " dir0"}, 32'(dir_err), 32'd0);
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        $display("fetch %s addr=%06h cs_len=%0d done=%0d late=%0d", tag, a, cs_len, done_cnt, late_cnt);
    endtask

    task automatic check_rd(input string tag, input int idx, input logic [3:0] exp);
        rd_idx = 8'(idx);
        #1;
        check($sformatf("%s idx%0d", tag, idx), 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst cs", 32'(spi_cs), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst late", 32'(late), 32'd0);
        check("rst out0", 32'(spi_out0), 32'd0);
        check("rst dir0", 32'(spi_dir0), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        // Fetch 1: bus framing, nibble j = j[3:0]
        clear_mon(); pat_mode = 0;
        pulse_start(24'h001240);
        check("f1 busy_high", 32'(busy), 32'd1);
        check("f1 cs_high", 32'(spi_cs), 32'd1);
        wait_done("f1");
        check_fetch("f1", 24'h001240);
        do_swap();
        for (int i = 0; i < NIBBLES; i++) check_rd("f1 rd", i, pat(0, i));
        check_rd("f1 rd_oob", 200, 4'h0);

        // Fetch 2 fills the other bank; read bank must keep fetch 1 data
        clear_mon(); pat_mode = 2;
        pulse_start(24'hABCDEF);
        for (int r = 0; r < 8; r++) begin
            repeat (20) @(posedge clk);
            #2;
            check_rd("f2 during", r * 17, pat(0, r * 17));
        end
        wait_done("f2");
        check_fetch("f2", 24'hABCDEF);
        do_swap();
        check_rd("f2 new", 0, 4'h5);
        check_rd("f2 new", 11, 4'h0);
        check_rd("f2 new", 135, 4'hC);
        do_swap();
        check_rd("f2 old", 0, 4'h0);
        check_rd("f2 old", 135, 4'h7);

        // Fetch 3: start during an active fetch is ignored
        clear_mon(); pat_mode = 3;
        pulse_start(24'h000100);
        wait_k(50, "f3");
        addr = 24'hFFFFFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("f3");
        check_fetch("f3", 24'h000100);
        check("f3 late_cnt", 32'(late_cnt), 32'd0);
        check("f3 idle_cs", 32'(spi_cs), 32'd0);

        // Fetch 4: swap while busy -> late, read bank flips, write bank unchanged
        clear_mon(); pat_mode = 0;
        pulse_start(24'h123456);
        wait_k(100, "f4");
        swap = 1'b1;
        @(posedge clk); #2;
        swap = 1'b0;
        check("f4 late_pulse", 32'(late), 32'd1);
        check_rd("f4 flipped", 130, 4'h6);
        wait_done("f4");
        check_fetch("f4", 24'h123456);
        check("f4 late_cnt", 32'(late_cnt), 32'd1);
        check_rd("f4 torn", 130, 4'h2);

        // Fetch 5 aborted by asynchronous reset at k=60, then a full fetch
        clear_mon();
        pulse_start(24'h000000);
        wait_k(60, "f5");
        #1;
        reset_n = 1'b0;
        #1;
        check("f5 rst cs", 32'(spi_cs), 32'd0);
        check("f5 rst busy", 32'(busy), 32'd0);
        check("f5 rst dir0", 32'(spi_dir0), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        clear_mon();
        pulse_start(24'h0F0F0F);
        wait_done("f6");
        check_fetch("f6", 24'h0F0F0F);

`ifdef QSPI_FETCH_CHECKSUM_EN
        clear_mon(); pat_mode = 1;
        pulse_start(24'h000200);
        wait_done("f7");
        check_fetch("f7", 24'h000200);
        check("f7 csum_at_done", 32'(csum_seen), 32'h0000_00F8);
        check("f7 csum_held", 32'(csum), 32'h0000_00F8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
